// File: rtl/fault_monitor.sv
// Fault-flag producer: checks each retiring instruction for illegal opcodes, contradictory
// control bits and a stuck ALU result, holds flags until acknowledged, and tracks pc_saved.
module fault_monitor #(
  parameter logic        ENABLE_FAULT_TOLERANCE = 1'b1,
  parameter int unsigned STUCK_LIMIT            = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [6:0]  opcode,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic        jump,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc_current,
  input  logic        safe_mode,
  input  logic        fault_ack,
  output logic        illegal_opcode,
  output logic        invalid_control,
  output logic        stuck_at_fault,
  output logic [31:0] pc_saved,
  output logic        fault_pending,
  output logic [7:0]  fault_count
);

  localparam logic [7:0] LP_LIMIT = 8'(STUCK_LIMIT);

  typedef enum logic [1:0] {ST_MONITOR, ST_FAULT, ST_COOLDOWN} state_t;

  state_t      r_state, w_next_state;
  logic        r_illegal, r_invalid, r_stuck;
  logic [31:0] r_pc_saved;
  logic [7:0]  r_count;
  logic [31:0] r_last_alu;
  logic [7:0]  r_rep;
  logic        r_have_last;

  logic        w_sample;
  logic        w_illegal, w_invalid, w_stuck, w_any;
  logic [7:0]  w_rep_next;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
      7'b0010111, 7'b1110011, 7'b0001111: is_legal_opcode = 1'b1;
      default:                            is_legal_opcode = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign w_sample  = instr_valid && !safe_mode && (r_state == ST_MONITOR);
  assign w_illegal = !is_legal_opcode(opcode);
  assign w_invalid = (mem_read && mem_write) || (branch && jump) || (mem_write && reg_write);

  // First sample after reset/cooldown starts a fresh run of length 1.
  always_comb begin
    w_rep_next = 8'd1;
    if (r_have_last && (alu_result == r_last_alu)) w_rep_next = sat_inc8(r_rep);
  end

  assign w_stuck = (w_rep_next == LP_LIMIT);
  assign w_any   = ENABLE_FAULT_TOLERANCE && (w_illegal || w_invalid || w_stuck);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_MONITOR:  if (w_sample && w_any) w_next_state = ST_FAULT;
      ST_FAULT:    if (fault_ack) w_next_state = ST_COOLDOWN;
      ST_COOLDOWN: w_next_state = ST_MONITOR;
      default:     w_next_state = ST_MONITOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_MONITOR;
      r_illegal   <= 1'b0;
      r_invalid   <= 1'b0;
      r_stuck     <= 1'b0;
      r_pc_saved  <= 32'h0;
      r_count     <= 8'd0;
      r_last_alu  <= 32'h0;
      r_rep       <= 8'd0;
      r_have_last <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_sample) begin
        r_last_alu  <= alu_result;
        r_rep       <= w_rep_next;
        r_have_last <= 1'b1;
        if (!w_any) r_pc_saved <= pc_current;
      end
      if (w_sample && w_any) begin
        r_illegal <= w_illegal;
        r_invalid <= w_invalid;
        r_stuck   <= w_stuck;
        r_count   <= sat_inc8(r_count);
      end
      if ((r_state == ST_FAULT) && fault_ack) begin
        r_illegal <= 1'b0;
        r_invalid <= 1'b0;
        r_stuck   <= 1'b0;
      end
      // Recovery restarts the stuck run so a retried sequence is judged afresh.
      if (r_state == ST_COOLDOWN) begin
        r_rep       <= 8'd0;
        r_have_last <= 1'b0;
      end
    end
  end

  assign illegal_opcode  = r_illegal;
  assign invalid_control = r_invalid;
  assign stuck_at_fault  = r_stuck;
  assign pc_saved        = r_pc_saved;
  assign fault_pending   = (r_state == ST_FAULT);
  assign fault_count     = r_count;

endmodule
